// File: rtl/gated_clock_div_monitor.sv
// gated_clock_div_monitor: recovers period/high time of a sampled divided clock, locks and predicts its next rise.
// Define DUTY_CHECK_EN to make high-time mismatches count against lock and raise ERR.
module gated_clock_div_monitor #(
  parameter int CW         = 8,
  parameter int LOCK_COUNT = 3
) (
  input  logic          CLK_IN,
  input  logic          RST,
  input  logic          SLOW_CLK,
  input  logic          SLOW_GATE,
  output logic          LOCKED,
  output logic [CW-1:0] PERIOD,
  output logic [CW-1:0] HIGH_CNT,
  output logic          PREEDGE_REC,
  output logic          ERR
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] MAX = '1;
  typedef enum logic [2:0] {IDLE, SEEK, MEASURE, VERIFY, LOCK} state_t;
  state_t state_q, state_d;
  logic s_q, s_qq, g_q, err_q, err_d;
  logic [CW-1:0] ph_q, ph_d, hi_q, hi_d, cand_p_q, cand_p_d, cand_h_q, cand_h_d;
  logic [CW-1:0] per_q, per_d, hc_q, hc_d;
  logic [MW-1:0] match_q, match_d, match_inc;
  logic [CW:0] per_p1;
  logic rise, sat, cand_ok, lock_bad;
  assign rise      = s_q & ~s_qq;
  assign sat       = ph_q == MAX;
  assign match_inc = match_q + MW'(1);
  assign per_p1    = {1'b0, per_q} + {{CW{1'b0}}, 1'b1};
`ifdef DUTY_CHECK_EN
  assign cand_ok  = (ph_q == cand_p_q) && (hi_q == cand_h_q);
  assign lock_bad = rise ? (ph_q != per_q || hi_q != hc_q) : ({1'b0, ph_q} == per_p1);
`else
  assign cand_ok  = ph_q == cand_p_q;
  assign lock_bad = rise ? (ph_q != per_q) : ({1'b0, ph_q} == per_p1);
`endif
  assign ph_d = rise ? CW'(1) : (sat ? ph_q : ph_q + CW'(1));
  assign hi_d = rise ? CW'(1) : ((s_q && hi_q != MAX) ? hi_q + CW'(1) : hi_q);
  always_comb begin
    state_d  = state_q;
    cand_p_d = cand_p_q;
    cand_h_d = cand_h_q;
    match_d  = match_q;
    per_d    = per_q;
    hc_d     = hc_q;
    err_d    = err_q;
    if (!g_q) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: if (rise) begin
          state_d = MEASURE;
          match_d = '0;
        end
        MEASURE: if (rise) begin
          cand_p_d = ph_q;
          cand_h_d = hi_q;
          match_d  = MW'(1);
          state_d  = (LOCK_COUNT == 1) ? LOCK : VERIFY;
          per_d    = (LOCK_COUNT == 1) ? ph_q : per_q;
          hc_d     = (LOCK_COUNT == 1) ? hi_q : hc_q;
        end else if (sat) state_d = SEEK;
        VERIFY: if (rise && cand_ok) begin
          match_d = match_inc;
          if (match_inc == MW'(LOCK_COUNT)) begin
            state_d = LOCK;
            per_d   = cand_p_q;
            hc_d    = cand_h_q;
          end
        end else if (rise) begin
          cand_p_d = ph_q;
          cand_h_d = hi_q;
          match_d  = MW'(1);
        end else if (sat) state_d = SEEK;
        LOCK: if (lock_bad) begin
          err_d   = 1'b1;
          state_d = SEEK;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      s_qq     <= 1'b0;
      g_q      <= 1'b0;
      ph_q     <= '0;
      hi_q     <= '0;
      cand_p_q <= '0;
      cand_h_q <= '0;
      match_q  <= '0;
      per_q    <= '0;
      hc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= SLOW_CLK;
      s_qq     <= s_q;
      g_q      <= SLOW_GATE;
      ph_q     <= ph_d;
      hi_q     <= hi_d;
      cand_p_q <= cand_p_d;
      cand_h_q <= cand_h_d;
      match_q  <= match_d;
      per_q    <= per_d;
      hc_q     <= hc_d;
      err_q    <= err_d;
    end
  end
  assign LOCKED      = state_q == LOCK;
  assign PERIOD      = per_q;
  assign HIGH_CNT    = hc_q;
  assign ERR         = err_q;
  assign PREEDGE_REC = (state_q == LOCK) && (ph_q == per_q - CW'(1));
endmodule

// File: tb/tb_gated_clock_div_monitor.sv
// tb_gated_clock_div_monitor: table-driven segments, hand sequences and random waveforms against an event-level model.
module tb_gated_clock_div_monitor;
  localparam int CW = 8;
  localparam int LC = 3;
  localparam int MAXV = 255;
`ifdef DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif
  logic CLK_IN = 1'b0, RST = 1'b1, SLOW_CLK = 1'b0, SLOW_GATE = 1'b0;
  logic LOCKED, PREEDGE_REC, ERR;
  logic [CW-1:0] PERIOD, HIGH_CNT;
  int checks = 0, errors = 0;
  bit m_s, m_sp, m_g, m_err;
  int m_age, m_high, m_cp, m_ch, m_per, m_hc;
  int m_streak = -2;
  typedef struct {
    bit rst; bit gate; int per; int hi; int reps;
    bit e_lock; int e_per; int e_hi; bit e_err;
  } vec_t;
  vec_t tbl[$];

  always #5 CLK_IN = ~CLK_IN;

  gated_clock_div_monitor #(.CW(CW), .LOCK_COUNT(LC)) dut (
    .CLK_IN(CLK_IN), .RST(RST), .SLOW_CLK(SLOW_CLK), .SLOW_GATE(SLOW_GATE),
    .LOCKED(LOCKED), .PERIOD(PERIOD), .HIGH_CNT(HIGH_CNT),
    .PREEDGE_REC(PREEDGE_REC), .ERR(ERR)
  );

  function automatic int satv(input int v);
    return v > MAXV ? MAXV : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // streak: -2 gated off, -1 waiting for first rise, 0 one rise seen, k>0 k agreeing periods
  task automatic model_step();
    bit rise, lk, bad;
    int ph, hh;
    if (RST) begin
      {m_s, m_sp, m_g, m_err} = '0;
      {m_age, m_high, m_cp, m_ch, m_per, m_hc} = '0;
      m_streak = -2;
    end else begin
      rise = m_s && !m_sp;
      ph = satv(m_age);
      hh = satv(m_high);
      lk = m_streak >= LC;
      if (!m_g) m_streak = -2;
      else if (m_streak == -2) m_streak = -1;
      else if (lk) begin
        bad = rise ? (ph != m_per || (DUTY && hh != m_hc)) : (ph == m_per + 1);
        if (bad) begin
          m_err = 1'b1;
          m_streak = -1;
        end
      end else if (rise) begin
        if (m_streak == -1) m_streak = 0;
        else begin
          if (m_streak > 0 && ph == m_cp && (!DUTY || hh == m_ch)) m_streak++;
          else begin
            m_cp = ph;
            m_ch = hh;
            m_streak = 1;
          end
          if (m_streak >= LC) begin
            m_per = m_cp;
            m_hc = m_ch;
          end
        end
      end else if (ph == MAXV) m_streak = -1;
      m_age = rise ? 1 : m_age + 1;
      m_high = rise ? 1 : (m_s ? m_high + 1 : m_high);
      m_sp = m_s;
      m_s = SLOW_CLK;
      m_g = SLOW_GATE;
    end
  endtask

  task automatic compare_model();
    bit lk;
    lk = m_streak >= LC;
    check("model_locked", LOCKED, lk);
    check("model_period", PERIOD, m_per);
    check("model_high_cnt", HIGH_CNT, m_hc);
    check("model_err", ERR, m_err);
    check("model_preedge", PREEDGE_REC, lk && satv(m_age) == m_per - 1);
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    model_step();
    @(negedge CLK_IN);
    compare_model();
  endtask

  // per=0 holds SLOW_CLK low for reps cycles; otherwise reps periods of per cycles, hi of them high
  task automatic drive(input int per, input int hi, input int reps);
    if (per == 0)
      for (int r = 0; r < reps; r++) begin
        SLOW_CLK = 1'b0;
        tick();
      end
    else
      for (int r = 0; r < reps; r++)
        for (int i = 0; i < per; i++) begin
          SLOW_CLK = (i < hi);
          tick();
        end
  endtask

  initial begin
    tbl.push_back('{1, 0, 0, 0, 2,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 3,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 3, 2, 4,   1, 3, 2, 0});
    tbl.push_back('{0, 1, 3, 2, 3,   1, 3, 2, 0});
    tbl.push_back('{1, 1, 0, 0, 2,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 3,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 2, 1, 5,   1, 2, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 2,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 3,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 5, 2, 4,   1, 5, 2, 0});
    tbl.push_back('{0, 0, 5, 2, 2,   0, 5, 2, 0});
    tbl.push_back('{0, 1, 5, 2, 5,   1, 5, 2, 0});
    tbl.push_back('{0, 1, 5, 3, 3,   !DUTY, 5, 2, DUTY});
    tbl.push_back('{1, 1, 0, 0, 2,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 3,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 5, 2, 4,   1, 5, 2, 0});
    tbl.push_back('{0, 1, 6, 2, 1,   1, 5, 2, 0});
    tbl.push_back('{0, 1, 5, 2, 5,   1, 5, 2, 1});
    tbl.push_back('{1, 1, 0, 0, 2,   0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 300, 0, 0, 0, 0});
    foreach (tbl[k]) begin
      RST = tbl[k].rst;
      SLOW_GATE = tbl[k].gate;
      drive(tbl[k].per, tbl[k].hi, tbl[k].reps);
      check($sformatf("tbl%0d_locked", k), LOCKED, tbl[k].e_lock);
      check($sformatf("tbl%0d_period", k), PERIOD, tbl[k].e_per);
      check($sformatf("tbl%0d_high_cnt", k), HIGH_CNT, tbl[k].e_hi);
      check($sformatf("tbl%0d_err", k), ERR, tbl[k].e_err);
    end
    RST = 1'b0;
    SLOW_GATE = 1'b1;
    drive(5, 2, 4);
    check("seq_lock5", LOCKED, 1);
    drive(4, 2, 5);
    check("seq_verify_unlocked", LOCKED, 0);
    check("seq_verify_err", ERR, 1);
    RST = 1'b1;
    SLOW_CLK = 1'b1;
    tick();
    check("seq_rst_locked", LOCKED, 0);
    check("seq_rst_period", PERIOD, 0);
    check("seq_rst_high", HIGH_CNT, 0);
    check("seq_rst_err", ERR, 0);
    check("seq_rst_preedge", PREEDGE_REC, 0);
    RST = 1'b0;
    drive(0, 0, 2);
    for (int n = 0; n < 300; n++) begin
      int per, hi;
      per = $urandom_range(1, 9);
      hi = per == 1 ? 1 : $urandom_range(1, per - 1);
      SLOW_GATE = ($urandom_range(0, 9) != 0);
      RST = ($urandom_range(0, 59) == 0);
      drive(per, hi, $urandom_range(1, 6));
      RST = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
